// File: rtl/memory_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: default bus widths used by
// both caches and data_memory, FSM state encoding, owner IDs and the
// busy-wait helper used for both requester stall outputs.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_WIDTH = 28;
  localparam int DEF_DATA_WIDTH = 128;

  typedef logic [1:0] arb_state_t;
  typedef logic [1:0] owner_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_ISSUE = 2'd1;
  localparam arb_state_t ST_WAIT  = 2'd2;
  localparam arb_state_t ST_DONE  = 2'd3;

  localparam owner_t OWN_NONE = 2'd0;
  localparam owner_t OWN_I    = 2'd1;
  localparam owner_t OWN_D    = 2'd2;

  // A requester is stalled while it requests, except in the DONE cycle of
  // its own transfer.
  function automatic logic busy_wait(input logic req, input arb_state_t state,
                                     input owner_t owner, input owner_t me);
    return req && !((state == ST_DONE) && (owner == me));
  endfunction

endpackage

// File: rtl/memory_bus_arbiter_arb_grant_select.sv
// Combinational grant pick between the I-cache and D-cache requests.
// Build option ARB_ROUND_ROBIN_EN: on a tie the requester that did not own
// the previous transfer wins; otherwise the D-cache always wins a tie.
module arb_grant_select
  import mem_arbiter_pkg::*;
(
  input  logic   i_req_i,
  input  logic   d_req_i,
  input  logic   last_owner_d_i,
  output logic   grant_valid_o,
  output owner_t grant_owner_o
);

`ifndef ARB_ROUND_ROBIN_EN
  logic unused_last_owner_s;
  assign unused_last_owner_s = last_owner_d_i;
`endif

  // Select the next owner from the live requests.
  always_comb begin
    grant_valid_o = i_req_i || d_req_i;
    grant_owner_o = OWN_NONE;
    if (d_req_i && i_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (last_owner_d_i) begin
        grant_owner_o = OWN_I;
      end else begin
        grant_owner_o = OWN_D;
      end
`else
      grant_owner_o = OWN_D;
`endif
    end else if (d_req_i) begin
      grant_owner_o = OWN_D;
    end else if (i_req_i) begin
      grant_owner_o = OWN_I;
    end else begin
      grant_owner_o = OWN_NONE;
    end
  end

endmodule

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: shares the single block-wide main-memory port between
// the I-cache (refills) and the D-cache (refills and write-backs). One whole
// block transfer at a time: IDLE -> ISSUE -> WAIT -> DONE -> IDLE. Request
// fields are latched at grant, so requester changes afterwards are ignored.
// Build option ARB_ROUND_ROBIN_EN adds a last-owner register for fair ties.
module memory_bus_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_READ,
  input  logic [ADDR_WIDTH-1:0] I_ADDRESS,
  output logic [DATA_WIDTH-1:0] I_READ_DATA,
  output logic                  I_BUSY_WAIT,
  input  logic                  D_READ,
  input  logic                  D_WRITE,
  input  logic [ADDR_WIDTH-1:0] D_ADDRESS,
  input  logic [DATA_WIDTH-1:0] D_WRITE_DATA,
  output logic [DATA_WIDTH-1:0] D_READ_DATA,
  output logic                  D_BUSY_WAIT,
  output logic                  MEM_READ,
  output logic                  MEM_WRITE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [DATA_WIDTH-1:0] MEM_WRITE_DATA,
  input  logic [DATA_WIDTH-1:0] MEM_READ_DATA,
  input  logic                  MEM_BUSY_WAIT
);

  arb_state_t            state_q, state_d;
  owner_t                owner_q, owner_d;
  logic                  write_q, write_d;
  logic                  mem_read_q, mem_read_d;
  logic                  mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic   d_req_s;
  logic   last_owner_d_s;
  logic   grant_valid_s;
  owner_t grant_owner_s;

  // D_READ together with D_WRITE is illegal and resolves to a write below.
  assign d_req_s = D_READ || D_WRITE;

  arb_grant_select u_grant (
    .i_req_i        (I_READ),
    .d_req_i        (d_req_s),
    .last_owner_d_i (last_owner_d_s),
    .grant_valid_o  (grant_valid_s),
    .grant_owner_o  (grant_owner_s)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner_q;

  assign last_owner_d_s = last_owner_q;

  // Remember which cache owned the most recent grant (reset: I-cache).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_owner_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && grant_valid_s) begin
      last_owner_q <= (grant_owner_s == OWN_D);
    end else begin
      last_owner_q <= last_owner_q;
    end
  end
`else
  assign last_owner_d_s = 1'b0;
`endif

  // Transfer sequencing, request latching and read-data capture.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    write_d     = write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid_s) begin
          owner_d = grant_owner_s;
          if (grant_owner_s == OWN_D) begin
            write_d = D_WRITE;
            addr_d  = D_ADDRESS;
            wdata_d = D_WRITE_DATA;
          end else begin
            write_d = 1'b0;
            addr_d  = I_ADDRESS;
            wdata_d = wdata_q;
          end
          mem_read_d  = !write_d;
          mem_write_d = write_d;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // Memory busy is not meaningful until it has seen the strobe.
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!MEM_BUSY_WAIT) begin
          if (!write_q && (owner_q == OWN_D)) begin
            d_rdata_d = MEM_READ_DATA;
          end else if (!write_q && (owner_q == OWN_I)) begin
            i_rdata_d = MEM_READ_DATA;
          end else begin
            d_rdata_d = d_rdata_q;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        owner_d = OWN_NONE;
        state_d = ST_IDLE;
      end
      default: begin
        owner_d     = OWN_NONE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_NONE;
      write_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      wdata_q     <= {DATA_WIDTH{1'b0}};
      i_rdata_q   <= {DATA_WIDTH{1'b0}};
      d_rdata_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      write_q     <= write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign MEM_READ       = mem_read_q;
  assign MEM_WRITE      = mem_write_q;
  assign MEM_ADDRESS    = addr_q;
  assign MEM_WRITE_DATA = wdata_q;
  assign I_READ_DATA    = i_rdata_q;
  assign D_READ_DATA    = d_rdata_q;

  // Stalls must drop in the DONE cycle itself, so they stay combinational.
  assign I_BUSY_WAIT = busy_wait(I_READ, state_q, owner_q, OWN_I);
  assign D_BUSY_WAIT = busy_wait(d_req_s, state_q, owner_q, OWN_D);

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Scoreboard bench for memory_bus_arbiter: randomized cache request rounds,
// a transaction-level arbitration/memory model, a memory responder with
// random latency, and monitors popping expected transfers and responses.
module tb_memory_bus_arbiter;

  typedef struct packed {
    logic         wr;
    logic         both;
    logic [27:0]  addr;
    logic [127:0] data;
  } op_t;

  logic         clock = 1'b0;
  logic         reset;
  logic         I_READ, D_READ, D_WRITE;
  logic [27:0]  I_ADDRESS, D_ADDRESS, MEM_ADDRESS;
  logic [127:0] I_READ_DATA, D_READ_DATA, D_WRITE_DATA;
  logic [127:0] MEM_WRITE_DATA, MEM_READ_DATA;
  logic         I_BUSY_WAIT, D_BUSY_WAIT, MEM_READ, MEM_WRITE, MEM_BUSY_WAIT;

  int tests = 0;
  int fails = 0;

  op_t d_ops[$], i_ops[$];
  op_t exp_xfer_q[$], exp_i_q[$], exp_d_q[$];
  logic [127:0] model_mem[logic [27:0]];
  logic [127:0] phys_mem[logic [27:0]];
  logic         model_last_d = 1'b0;
  logic [127:0] exp_i_last = '0;
  logic [127:0] exp_d_last = '0;

  int   fixed_lat = -1;
  logic mem_hold = 1'b0;
  logic in_xfer = 1'b0;
  logic cur_wr;
  logic [27:0] cur_addr;
  int   lat;

  memory_bus_arbiter dut (
    .clock(clock), .reset(reset),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READ_DATA(I_READ_DATA), .I_BUSY_WAIT(I_BUSY_WAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITE_DATA(D_WRITE_DATA),
    .D_READ_DATA(D_READ_DATA), .D_BUSY_WAIT(D_BUSY_WAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITE_DATA(MEM_WRITE_DATA), .MEM_READ_DATA(MEM_READ_DATA), .MEM_BUSY_WAIT(MEM_BUSY_WAIT)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Initial memory contents for never-written blocks.
  function automatic logic [127:0] pattern(input logic [27:0] a);
    logic [31:0] w;
    w = {4'h0, a};
    return {w ^ 32'hA5A5A5A5, ~w, w + 32'h01010101, w ^ 32'h5A5A0F0F};
  endfunction

  function automatic op_t mk_op(input logic wr, input logic [27:0] a, input logic [127:0] d);
    op_t o;
    o.wr = wr; o.both = 1'b0; o.addr = a; o.data = d;
    return o;
  endfunction

  function automatic op_t rand_op(input logic allow_wr);
    op_t o;
    o.wr   = allow_wr && ($urandom_range(0, 1) == 1);
    o.both = o.wr && ($urandom_range(0, 3) == 0);
    o.addr = 28'($urandom_range(0, 15));
    o.data = {$urandom, $urandom, $urandom, $urandom};
    return o;
  endfunction

  // Reference model: whole transfers in grant order, with memory contents.
  task automatic plan_round();
    op_t dq[$];
    op_t iq[$];
    op_t o;
    logic pick_d;
    dq = d_ops;
    iq = i_ops;
    while (dq.size() > 0 || iq.size() > 0) begin
      if (dq.size() > 0 && iq.size() > 0) begin
`ifdef ARB_ROUND_ROBIN_EN
        pick_d = !model_last_d;
`else
        pick_d = 1'b1;
`endif
      end else begin
        pick_d = (dq.size() > 0);
      end
      if (pick_d) o = dq.pop_front();
      else        o = iq.pop_front();
      model_last_d = pick_d;
      if (o.wr) model_mem[o.addr] = o.data;
      else      o.data = model_mem.exists(o.addr) ? model_mem[o.addr] : pattern(o.addr);
      exp_xfer_q.push_back(o);
      if (pick_d) exp_d_q.push_back(o);
      else        exp_i_q.push_back(o);
    end
  endtask

  task automatic wait_done(input logic is_d);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((is_d ? D_BUSY_WAIT : I_BUSY_WAIT) && n < 300);
    if (is_d ? D_BUSY_WAIT : I_BUSY_WAIT) fail_now(is_d ? "d_timeout" : "i_timeout");
  endtask

  task automatic drive_d();
    op_t o;
    while (d_ops.size() > 0) begin
      o = d_ops.pop_front();
      D_WRITE = o.wr;
      D_READ = !o.wr || o.both;
      D_ADDRESS = o.addr;
      D_WRITE_DATA = o.data;
      wait_done(1'b1);
      @(posedge clock); #1;
    end
    D_READ = 1'b0;
    D_WRITE = 1'b0;
  endtask

  task automatic drive_i();
    op_t o;
    while (i_ops.size() > 0) begin
      o = i_ops.pop_front();
      I_READ = 1'b1;
      I_ADDRESS = o.addr;
      wait_done(1'b0);
      @(posedge clock); #1;
    end
    I_READ = 1'b0;
  endtask

  task automatic run_round();
    @(posedge clock); #1;
    plan_round();
    fork
      drive_d();
      drive_i();
    join
    repeat (2) @(posedge clock);
    check("round_drain", 128'(exp_xfer_q.size() + exp_i_q.size() + exp_d_q.size()), 128'd0);
  endtask

  // Memory responder; also checks each transfer as it is issued.
  always @(negedge clock) begin
    op_t e;
    if (!reset) begin
      in_xfer = 1'b0;
      MEM_BUSY_WAIT = 1'b1;
    end else if (!in_xfer) begin
      if (MEM_READ || MEM_WRITE) begin
        if (exp_xfer_q.size() == 0) begin
          fail_now("unexpected_xfer");
        end else begin
          e = exp_xfer_q.pop_front();
          check("xfer_write", 128'(MEM_WRITE), 128'(e.wr));
          check("xfer_read", 128'(MEM_READ), 128'(!e.wr));
          check("xfer_addr", 128'(MEM_ADDRESS), 128'(e.addr));
          if (e.wr) check("xfer_wdata", MEM_WRITE_DATA, e.data);
        end
        in_xfer = 1'b1;
        cur_wr = MEM_WRITE;
        cur_addr = MEM_ADDRESS;
        MEM_READ_DATA = phys_mem.exists(MEM_ADDRESS) ? phys_mem[MEM_ADDRESS] : pattern(MEM_ADDRESS);
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 5));
        MEM_BUSY_WAIT = 1'b1;
      end
    end else if (MEM_READ || MEM_WRITE) begin
      if (mem_hold) begin
        MEM_BUSY_WAIT = 1'b1;
      end else if (lat == 0) begin
        MEM_BUSY_WAIT = 1'b0;
        if (cur_wr) phys_mem[cur_addr] = MEM_WRITE_DATA;
      end else begin
        lat--;
      end
    end else begin
      in_xfer = 1'b0;
      MEM_BUSY_WAIT = 1'b1;
    end
  end

  // Response monitor: completions, held read data, idle stalls.
  always @(negedge clock) begin
    op_t e;
    if (reset) begin
      if (I_READ && !I_BUSY_WAIT) begin
        if (exp_i_q.size() == 0) fail_now("i_unexpected_done");
        else begin
          e = exp_i_q.pop_front();
          exp_i_last = e.data;
        end
      end
      if ((D_READ || D_WRITE) && !D_BUSY_WAIT) begin
        if (exp_d_q.size() == 0) fail_now("d_unexpected_done");
        else begin
          e = exp_d_q.pop_front();
          if (!e.wr) exp_d_last = e.data;
        end
      end
      check("i_read_data", I_READ_DATA, exp_i_last);
      check("d_read_data", D_READ_DATA, exp_d_last);
      if (!I_READ) check("i_idle_busy", 128'(I_BUSY_WAIT), 128'd0);
      if (!(D_READ || D_WRITE)) check("d_idle_busy", 128'(D_BUSY_WAIT), 128'd0);
    end
  end

  initial begin
    int n;
    op_t o;
    reset = 1'b0;
    I_READ = 1'b0; D_READ = 1'b0; D_WRITE = 1'b0;
    I_ADDRESS = '0; D_ADDRESS = '0; D_WRITE_DATA = '0;
    MEM_READ_DATA = '0; MEM_BUSY_WAIT = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("rst_mem_read", 128'(MEM_READ), 128'd0);
    check("rst_mem_write", 128'(MEM_WRITE), 128'd0);
    check("rst_mem_addr", 128'(MEM_ADDRESS), 128'd0);
    check("rst_mem_wdata", MEM_WRITE_DATA, 128'd0);
    check("rst_i_data", I_READ_DATA, 128'd0);
    check("rst_d_data", D_READ_DATA, 128'd0);
    check("rst_i_busy", 128'(I_BUSY_WAIT), 128'd0);
    #1 reset = 1'b1;

    // I-cache refill alone with a slow memory.
    fixed_lat = 4;
    i_ops.push_back(mk_op(1'b0, 28'h0000010, 128'd0));
    run_round();
    fixed_lat = -1;
    // D-cache write-back.
    d_ops.push_back(mk_op(1'b1, 28'h0000020, {32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hDEADBEEF}));
    run_round();
    // Simultaneous refills.
    d_ops.push_back(mk_op(1'b0, 28'h0000020, 128'd0));
    i_ops.push_back(mk_op(1'b0, 28'h0000030, 128'd0));
    run_round();
    // Write-back then refill with an I refill pending.
    d_ops.push_back(mk_op(1'b1, 28'h0000040, {4{32'hCAFEF00D}}));
    d_ops.push_back(mk_op(1'b0, 28'h0000041, 128'd0));
    i_ops.push_back(mk_op(1'b0, 28'h0000040, 128'd0));
    run_round();
    // Four simultaneous pairs back to back.
    for (int k = 0; k < 4; k++) begin
      d_ops.push_back(mk_op(1'b0, 28'(k), 128'd0));
      i_ops.push_back(mk_op(1'b0, 28'(k + 8), 128'd0));
      run_round();
    end
    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      int nd, ni;
      nd = $urandom_range(0, 2);
      ni = $urandom_range(0, 1);
      if (nd == 0 && ni == 0) ni = 1;
      for (int k = 0; k < nd; k++) d_ops.push_back(rand_op(1'b1));
      for (int k = 0; k < ni; k++) i_ops.push_back(rand_op(1'b0));
      run_round();
    end

    // Reset asserted while a refill is waiting on memory.
    mem_hold = 1'b1;
    @(posedge clock); #1;
    o = mk_op(1'b0, 28'h0000033, 128'd0);
    exp_xfer_q.push_back(o);
    I_READ = 1'b1;
    I_ADDRESS = o.addr;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!MEM_READ && n < 20);
    @(negedge clock);
    @(negedge clock);
    #2;
    check("pre_rst_mem_read", 128'(MEM_READ), 128'd1);
    reset = 1'b0;
    I_READ = 1'b0;
    exp_i_last = '0;
    exp_d_last = '0;
    model_last_d = 1'b0;
    #1;
    check("abort_mem_read", 128'(MEM_READ), 128'd0);
    check("abort_mem_write", 128'(MEM_WRITE), 128'd0);
    check("abort_i_data", I_READ_DATA, 128'd0);
    check("abort_d_data", D_READ_DATA, 128'd0);
    check("abort_mem_addr", 128'(MEM_ADDRESS), 128'd0);
    mem_hold = 1'b0;
    @(negedge clock); #2;
    reset = 1'b1;
    check("abort_leftover", 128'(exp_xfer_q.size()), 128'd0);

    // Recovery after the abort.
    i_ops.push_back(mk_op(1'b0, 28'h0000005, 128'd0));
    d_ops.push_back(mk_op(1'b0, 28'h0000006, 128'd0));
    run_round();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
